carry_select_subtractor_pipe: RTL and testbench

- Two-stage pipelined 32-bit carry-select subtractor computing D = A - B - Bin with borrow-out. It is the subtraction counterpart of the team's carry-select adder.
- Valid/ready handshake on both sides. It sits in the arithmetic datapath feeding ALU/compare logic.
- Stage 1 computes the lower-half difference and both upper-half candidates. Stage 2 selects the upper half using the lower borrow.

---
 rtl/carry_select_subtractor_pipe.sv | 126 ++++++++++++
 tb/tb_carry_select_subtractor_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage pipelined carry-select subtractor: D = A - B - Bin, Bout = borrow-out.
// Optional signed-overflow output OVF is enabled by defining CSS_SIGNED_OVF_EN.

module csss_seg_sub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);
    logic [W:0] sum;

    // Subtraction as a + ~b + ~bin; the borrow is the inverted carry.
    assign sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bin};
    assign diff = sum[W-1:0];
    assign bout = ~sum[W];
endmodule

module carry_select_subtractor_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
`ifdef CSS_SIGNED_OVF_EN
    output logic             OVF,
`endif
    output logic             Bout
);
    localparam int HI = WIDTH - SPLIT;

    logic             s2_en, s1_en, xfer_in;
    logic [SPLIT-1:0] lo_d;
    logic             lo_b;
    logic [HI-1:0]    hi0_d, hi1_d;
    logic             hi0_b, hi1_b;

    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_blo;
    logic [HI-1:0]    s1_hi0, s1_hi1;
    logic             s1_b0, s1_b1;

    logic [HI-1:0]    sel_hi;
    logic             sel_b;

    assign s2_en    = !out_valid | out_ready;
    assign s1_en    = !s1_valid | s2_en;
    assign in_ready = s1_en & !rst;
    assign xfer_in  = in_valid & in_ready;

    csss_seg_sub #(.W(SPLIT)) u_lo (
        .a(A[SPLIT-1:0]), .b(B[SPLIT-1:0]), .bin(Bin), .diff(lo_d), .bout(lo_b)
    );
    // Both upper candidates are formed up front; stage 2 picks one by the lower borrow.
    csss_seg_sub #(.W(HI)) u_hi0 (
        .a(A[WIDTH-1:SPLIT]), .b(B[WIDTH-1:SPLIT]), .bin(1'b0), .diff(hi0_d), .bout(hi0_b)
    );
    csss_seg_sub #(.W(HI)) u_hi1 (
        .a(A[WIDTH-1:SPLIT]), .b(B[WIDTH-1:SPLIT]), .bin(1'b1), .diff(hi1_d), .bout(hi1_b)
    );

    assign {sel_b, sel_hi} = s1_blo ? {s1_b1, s1_hi1} : {s1_b0, s1_hi0};

`ifdef CSS_SIGNED_OVF_EN
    logic s1_amsb, s1_bmsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_amsb <= 1'b0;
            s1_bmsb <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            if (xfer_in) begin
                s1_amsb <= A[WIDTH-1];
                s1_bmsb <= B[WIDTH-1];
            end
            if (s2_en && s1_valid)
                OVF <= (s1_amsb != s1_bmsb) & (sel_hi[HI-1] != s1_amsb);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_blo    <= 1'b0;
            s1_hi0    <= '0;
            s1_b0     <= 1'b0;
            s1_hi1    <= '0;
            s1_b1     <= 1'b0;
            out_valid <= 1'b0;
            D         <= '0;
            Bout      <= 1'b0;
        end else begin
            if (s1_en)
                s1_valid <= in_valid;
            if (xfer_in) begin
                s1_lo  <= lo_d;
                s1_blo <= lo_b;
                s1_hi0 <= hi0_d;
                s1_b0  <= hi0_b;
                s1_hi1 <= hi1_d;
                s1_b1  <= hi1_b;
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    D    <= {sel_hi, s1_lo};
                    Bout <= sel_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// Directed self-checking bench for carry_select_subtractor_pipe (OVF checks when CSS_SIGNED_OVF_EN).

module tb_carry_select_subtractor_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] A, B;
    logic        Bin;
    logic        out_valid, out_ready;
    logic [31:0] D;
    logic        Bout;
`ifdef CSS_SIGNED_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    carry_select_subtractor_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .D(D),
`ifdef CSS_SIGNED_OVF_EN
        .OVF(ovf),
`endif
        .Bout(Bout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: 33-bit unsigned subtraction, bit 32 is the borrow.
    function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {32'd0, bin};
    endfunction

    // One isolated op with out_ready=1: result appears on the second edge after transfer.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input logic [31:0] exp_d, input logic exp_b, input logic exp_ovf);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        check({tag, "_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, out_valid, 0);
        step();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_D"}, D, exp_d);
        check({tag, "_Bout"}, Bout, exp_b);
`ifdef CSS_SIGNED_OVF_EN
        check({tag, "_OVF"}, ovf, exp_ovf);
`endif
        step();
        check({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        logic [31:0] va[8], vb[8];
        logic        vc[8];
        logic [32:0] exp_r[8];
        logic [31:0] pa[5], pb[5];
        logic [32:0] pr0, pr1;
        int          idx;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Bin = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_D", D, 0);
        check("rst_Bout", Bout, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        do_op("op_5_3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        do_op("op_0_1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("op_eq_bin", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("op_xsplit", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
        do_op("op_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);

        // Back-to-back stream, full throughput.
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom; vb[i] = $urandom; vc[i] = 1'($urandom_range(0, 1));
            exp_r[i] = ref_sub(va[i], vb[i], vc[i]);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                A = va[i]; B = vb[i]; Bin = vc[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 8) begin
                check($sformatf("stream%0d_valid", i - 1), out_valid, 1);
                check($sformatf("stream%0d_D", i - 1), D, exp_r[i-1][31:0]);
                check($sformatf("stream%0d_Bout", i - 1), Bout, exp_r[i-1][32]);
            end else begin
                check($sformatf("stream_idle%0d", i), out_valid, 0);
            end
        end

        // Backpressure: source holds operands until accepted.
        for (int i = 0; i < 5; i++) begin
            pa[i] = 32'h1000_0000 * (i + 1) + 32'h0000_8000;
            pb[i] = 32'h0000_9000 + i;
        end
        pr0 = ref_sub(pa[0], pb[0], 1'b0);
        pr1 = ref_sub(pa[1], pb[1], 1'b0);
        out_ready = 1'b0; Bin = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            A = pa[idx]; B = pb[idx]; in_valid = 1'b1;
            #0;
            if (in_ready) idx++;
            step();
            if (c >= 2) begin
                check($sformatf("bp_stall%0d_in_ready", c), in_ready, 0);
                check($sformatf("bp_stall%0d_D", c), D, pr0[31:0]);
                check($sformatf("bp_stall%0d_valid", c), out_valid, 1);
            end
        end
        check("bp_accepted", idx, 2);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_drain0_D", D, pr0[31:0]);
        check("bp_drain0_Bout", Bout, pr0[32]);
        step();
        check("bp_drain1_valid", out_valid, 1);
        check("bp_drain1_D", D, pr1[31:0]);
        check("bp_drain1_Bout", Bout, pr1[32]);
        step();
        check("bp_drain_empty", out_valid, 0);

        // Reset with both stages full.
        out_ready = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h0000_0001; in_valid = 1'b1;
        step();
        A = 32'h0000_0001; B = 32'h0000_0002;
        step();
        check("rstmid_full", out_valid, 1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        check("rstmid_valid", out_valid, 0);
        check("rstmid_D", D, 0);
        check("rstmid_Bout", Bout, 0);
        check("rstmid_in_ready", in_ready, 0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check("rstmid_post_ready", in_ready, 1);
        do_op("op_post_rst", 32'd7, 32'd9, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        do_op("op_5_3_b", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
